// File: rtl/multi_channel_fast_fifo_pkg.sv
// multi_channel_fast_fifo_pkg: shared sizing helpers for the multi-channel FIFO and its arbiter
package multi_channel_fast_fifo_pkg;

   function automatic int cbWidth(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

   function automatic int almostFullLevel(input int depthLog2, input int margin);
      return (1 << depthLog2) - margin;
   endfunction

endpackage

// File: rtl/multi_channel_fast_fifo_rr_arbiter.sv
// rr_arbiter: rotating-priority grant over N requests; ports clk, rstN, request[N] in, grant[N]/grantIdx/grantValid out
module rr_arbiter
   import multi_channel_fast_fifo_pkg::*;
#(
   parameter  int N  = 4,
   localparam int CB = cbWidth(N)
)(
   input  logic          clk,
   input  logic          rstN,
   input  logic [N-1:0]  request,
   output logic [N-1:0]  grant,
   output logic [CB-1:0] grantIdx,
   output logic          grantValid
);
   logic [CB-1:0] lastIdx;
   always_comb begin
      grantIdx   = '0;
      grantValid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!grantValid && request[(int'(lastIdx) + 1 + k) % N]) begin
            grantValid = 1'b1;
            grantIdx   = CB'((int'(lastIdx) + 1 + k) % N);
         end
      end
   end
   assign grant = N'(grantValid) << grantIdx;
   // Reset to the last channel so the first search begins at channel 0
   always_ff @(posedge clk or negedge rstN)
      if (!rstN) lastIdx <= CB'(N - 1);
      else if (grantValid) lastIdx <= grantIdx;
endmodule

// File: rtl/multi_channel_fast_fifo.sv
// multi_channel_fast_fifo: CHANNELS FIFOs in one shared memory; ports clk/rstN, write side (writeEnable, writeChannel, dataIn), per-channel status (usedw, empty, full, almostFull), read side (readRequest in; dataOut, dataOutChannel, dataOutValid out), sticky overflowError
module multi_channel_fast_fifo
   import multi_channel_fast_fifo_pkg::*;
#(
   parameter  int WIDTH              = 20,
   parameter  int DEPTH_LOG2         = 5,
   parameter  int CHANNELS           = 4,
   parameter  int MEM_OUT_STAGES     = 0,
   parameter  int ALMOST_FULL_MARGIN = 4,
   localparam int CB                 = cbWidth(CHANNELS),
   localparam int UW                 = DEPTH_LOG2 + 1
)(
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   writeEnable,
   input  logic [CB-1:0]          writeChannel,
   input  logic [WIDTH-1:0]       dataIn,
   output logic [CHANNELS*UW-1:0] usedw,
   output logic [CHANNELS-1:0]    empty,
   output logic [CHANNELS-1:0]    full,
   output logic [CHANNELS-1:0]    almostFull,
   input  logic [CHANNELS-1:0]    readRequest,
   output logic [WIDTH-1:0]       dataOut,
   output logic [CB-1:0]          dataOutChannel,
   output logic                   dataOutValid,
   output logic                   overflowError
);
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int WORDS  = CHANNELS * DEPTH;
   localparam int AW     = $clog2(WORDS);
   localparam int AF     = almostFullLevel(DEPTH_LOG2, ALMOST_FULL_MARGIN);
   localparam int STAGES = 1 + MEM_OUT_STAGES;

   logic [UW-1:0]              wp [CHANNELS];
   logic [UW-1:0]              rp [CHANNELS];
   logic [CHANNELS-1:0]        grant;
   logic [CB-1:0]              grantIdx;
   logic                       grantValid;
   logic [CB-1:0]              wCh;
   logic                       writeAccept;
   logic                       writeDrop;
   logic [AW-1:0]              wAddr;
   logic [AW-1:0]              rAddrNext;
   logic [AW-1:0]              rAddr;
   logic [WIDTH-1:0]           mem [WORDS];
   logic [WIDTH-1:0]           memQ;
   logic [STAGES-1:0]          pipeValid;
   logic [STAGES-1:0][CB-1:0]  pipeCh;

   assign wCh = CHANNELS == 1 ? '0 : writeChannel;

   for (genvar c = 0; c < CHANNELS; c++) begin : gCh
      logic [UW-1:0] used;
      assign used                 = wp[c] - rp[c];
      assign usedw[c*UW +: UW]    = used;
      assign empty[c]             = used == '0;
      assign full[c]              = used == UW'(DEPTH);
      assign almostFull[c]        = int'(used) >= AF;
   end

   rr_arbiter #(.N(CHANNELS)) uArb (
      .clk        (clk),
      .rstN       (rstN),
      .request    (readRequest & ~empty),
      .grant      (grant),
      .grantIdx   (grantIdx),
      .grantValid (grantValid)
   );

   // Channel c owns the address block starting at c*DEPTH
   always_comb begin
      writeAccept = 1'b0;
      writeDrop   = 1'b0;
      wAddr       = '0;
      rAddrNext   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (int'(wCh) == c) begin
            writeAccept = writeEnable && !full[c];
            writeDrop   = writeEnable && full[c];
            wAddr       = AW'(c * DEPTH + int'(wp[c][DEPTH_LOG2-1:0]));
         end
         if (grant[c]) rAddrNext = AW'(c * DEPTH + int'(rp[c][DEPTH_LOG2-1:0]));
      end
   end

   always_ff @(posedge clk or negedge rstN)
      if (!rstN) begin
         for (int c = 0; c < CHANNELS; c++) begin
            wp[c] <= '0;
            rp[c] <= '0;
         end
         overflowError <= 1'b0;
         pipeValid     <= '0;
         pipeCh        <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (writeAccept && int'(wCh) == c) wp[c] <= wp[c] + 1'b1;
            if (grant[c]) rp[c] <= rp[c] + 1'b1;
         end
         if (writeDrop) overflowError <= 1'b1;
         pipeValid <= STAGES'({pipeValid, grantValid});
         pipeCh    <= (STAGES*CB)'({pipeCh, grantIdx});
      end

   // Memory contents and read address carry no reset
   always_ff @(posedge clk) begin
      if (writeAccept) mem[wAddr] <= dataIn;
      if (grantValid) rAddr <= rAddrNext;
   end
   assign memQ = mem[rAddr];

   if (MEM_OUT_STAGES == 0) begin : gNoPipe
      assign dataOut = memQ;
   end else begin : gPipe
      logic [MEM_OUT_STAGES-1:0][WIDTH-1:0] dPipe;
      always_ff @(posedge clk) dPipe <= (MEM_OUT_STAGES*WIDTH)'({dPipe, memQ});
      assign dataOut = dPipe[MEM_OUT_STAGES-1];
   end

   assign dataOutValid   = pipeValid[STAGES-1];
   assign dataOutChannel = pipeCh[STAGES-1];
endmodule

// File: tb/tb_multi_channel_fast_fifo.sv
// tb_multi_channel_fast_fifo: randomized check of two FIFO instances (0 and 2 output stages) against a queue model
module tb_multi_channel_fast_fifo;
   localparam int W  = 20;
   localparam int D  = 32;
   localparam int C  = 4;
   localparam int UW = 6;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             writeEnable = 1'b0;
   logic [1:0]       writeChannel = '0;
   logic [W-1:0]     dataIn = '0;
   logic [C-1:0]     readRequest = '0;
   logic [C*UW-1:0]  usedw0, usedw2;
   logic [C-1:0]     empty0, empty2, full0, full2, af0, af2;
   logic [W-1:0]     dout0, dout2;
   logic [1:0]       ch0, ch2;
   logic             valid0, valid2, ovf0, ovf2;

   always #5 clk = ~clk;

   multi_channel_fast_fifo #(.MEM_OUT_STAGES(0)) dut0 (
      .clk(clk), .rstN(rstN), .writeEnable(writeEnable), .writeChannel(writeChannel), .dataIn(dataIn),
      .usedw(usedw0), .empty(empty0), .full(full0), .almostFull(af0), .readRequest(readRequest),
      .dataOut(dout0), .dataOutChannel(ch0), .dataOutValid(valid0), .overflowError(ovf0)
   );
   multi_channel_fast_fifo #(.MEM_OUT_STAGES(2)) dut2 (
      .clk(clk), .rstN(rstN), .writeEnable(writeEnable), .writeChannel(writeChannel), .dataIn(dataIn),
      .usedw(usedw2), .empty(empty2), .full(full2), .almostFull(af2), .readRequest(readRequest),
      .dataOut(dout2), .dataOutChannel(ch2), .dataOutValid(valid2), .overflowError(ovf2)
   );

   typedef struct {int cyc; int ch; int data;} exp_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last = C - 1;
   bit   ovfM = 1'b0;
   int   q [C][$];
   exp_t e [2][$];

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic checkOut(int k, logic v, logic [1:0] ch, logic [W-1:0] d);
      bit ev;
      ev = e[k].size() > 0 && e[k][0].cyc == cyc;
      chk($sformatf("valid%0d", k), v, ev);
      if (ev) begin
         chk($sformatf("chan%0d", k), ch, e[k][0].ch);
         chk($sformatf("data%0d", k), d, e[k][0].data);
         void'(e[k].pop_front());
      end
   endtask

   task automatic checkAll();
      logic [C*UW-1:0] mu;
      logic [C-1:0]    me, mf, ma;
      for (int c = 0; c < C; c++) begin
         mu[c*UW +: UW] = UW'(q[c].size());
         me[c] = q[c].size() == 0;
         mf[c] = q[c].size() == D;
         ma[c] = q[c].size() >= D - 4;
      end
      chk("usedw0", usedw0, mu);
      chk("usedw2", usedw2, mu);
      chk("empty0", empty0, me);
      chk("empty2", empty2, me);
      chk("full0", full0, mf);
      chk("full2", full2, mf);
      chk("almostFull0", af0, ma);
      chk("almostFull2", af2, ma);
      chk("overflow0", ovf0, ovfM);
      chk("overflow2", ovf2, ovfM);
      checkOut(0, valid0, ch0, dout0);
      checkOut(1, valid2, ch2, dout2);
   endtask

   // One clock: apply inputs, advance the model by one cycle, check after the edge
   task automatic step(bit we, int wch, int din, logic [3:0] rr);
      int   g = -1;
      bit   acc;
      exp_t x;
      writeEnable  = we;
      writeChannel = 2'(wch);
      dataIn       = W'(din);
      readRequest  = rr;
      acc = we && q[wch].size() < D;
      if (we && !acc) ovfM = 1'b1;
      for (int k = 0; k < C; k++) begin
         int c = (last + 1 + k) % C;
         if (g < 0 && rr[c] && q[c].size() > 0) g = c;
      end
      if (g >= 0) begin
         last   = g;
         x.ch   = g;
         x.data = q[g].pop_front();
         x.cyc  = cyc + 1;
         e[0].push_back(x);
         x.cyc  = cyc + 3;
         e[1].push_back(x);
      end
      if (acc) q[wch].push_back(din & 'hFFFFF);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      checkAll();
   endtask

   task automatic doReset();
      rstN        = 1'b0;
      writeEnable = 1'b0;
      readRequest = '0;
      #1;
      chk("rst_valid0", valid0, 1'b0);
      chk("rst_valid2", valid2, 1'b0);
      chk("rst_chan0", ch0, 2'd0);
      chk("rst_chan2", ch2, 2'd0);
      chk("rst_empty", empty0, 4'hF);
      chk("rst_full", full0, 4'h0);
      chk("rst_af", af0, 4'h0);
      chk("rst_usedw", usedw0, '0);
      chk("rst_ovf", ovf0, 1'b0);
      for (int c = 0; c < C; c++) q[c].delete();
      e[0].delete();
      e[1].delete();
      last = C - 1;
      ovfM = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      checkAll();
   endtask

   initial begin
      doReset();
      for (int v = 0; v < 32; v++) step(1'b1, 2, v, 4'b0000);
      step(1'b1, 2, 32, 4'b0000);
      repeat (34) step(1'b0, 0, 0, 4'b0100);
      doReset();
      step(1'b1, 1, 'hA, 4'b0000);
      step(1'b1, 1, 'hB, 4'b0000);
      repeat (6) step(1'b0, 0, 0, 4'b0010);
      for (int c = 0; c < C; c++)
         for (int i = 0; i < 4; i++) step(1'b1, c, int'($urandom), 4'b0000);
      repeat (20) step(1'b0, 0, 0, 4'hF);
      for (int v = 0; v < 100; v++) step(1'b1, 0, v, 4'b0001);
      repeat (4) step(1'b0, 0, 0, 4'b0001);
      doReset();
      for (int v = 0; v < 32; v++) step(1'b1, 3, v + 500, 4'b0000);
      step(1'b1, 3, 999, 4'b1000);
      repeat (5) step(1'b0, 0, 0, 4'b0000);
      doReset();
      for (int i = 0; i < 3; i++) step(1'b1, 1, i + 7, 4'b0000);
      readRequest = 4'b0010;
      @(posedge clk);
      @(posedge clk);
      #2;
      doReset();
      repeat (4) step(1'b0, 0, 0, 4'hF);
      repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 3), int'($urandom), 4'($urandom_range(0, 15)));
      repeat (200) step($urandom_range(0, 3) == 0, $urandom_range(0, 3), int'($urandom), 4'($urandom_range(0, 15)));
      repeat (10) step(1'b0, 0, 0, 4'hF);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
